// File: rtl/ula_exec_stage_pkg.sv
// Shared opcode constants, FSM encoding and width defaults for the ULA execute stage.
package ula_exec_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEST_W_DEF = 5;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_GREATER = 3'b010;
  localparam logic [2:0] OP_LESS    = 3'b011;
  localparam logic [2:0] OP_EQUAL   = 3'b100;

  // Occupancy of the two-entry skid buffer
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/ula_exec_stage_ula.sv
// Combinational ALU: unsigned add/sub and compares; unknown opcodes produce zero.
module ula_exec_stage_ula
  import ula_exec_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (sel)
      OP_ADD:     result = a + b;
      OP_SUB:     result = a - b;
      OP_GREATER: result[0] = (a > b);
      OP_LESS:    result[0] = (a < b);
      OP_EQUAL:   result[0] = (a == b);
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/ula_exec_stage.sv
// ALU execute stage with a 2-entry skid buffer on the result side.
// Optional accepted-operation counter enabled by defining ULA_EXEC_CNT_EN.
module ula_exec_stage
  import ula_exec_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEST_W = DEST_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_sel,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DEST_W-1:0] out_dest
`ifdef ULA_EXEC_CNT_EN
  ,
  output logic [15:0]       op_count
`endif
);

  state_t              state, state_nxt;
  logic                accept, xfer;
  logic                load_main, load_skid, skid_to_main;
  logic [DATA_W-1:0]   result;
  logic [DATA_W-1:0]   skid_data;
  logic [DEST_W-1:0]   skid_dest;

  ula_exec_stage_ula #(.DATA_W(DATA_W)) u_ula (
    .sel    (in_sel),
    .a      (in_data1),
    .b      (in_data2),
    .result (result)
  );

  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;
  assign out_valid = (state != ST_EMPTY);

  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        case ({accept, xfer})
          2'b11: load_main = 1'b1;
          2'b10: begin
            load_skid = 1'b1;
            state_nxt = ST_TWO;
          end
          2'b01: state_nxt = ST_EMPTY;
          default: state_nxt = ST_ONE;
        endcase
      end
      ST_TWO: begin
        // in_ready is low here, so only the drain side can move
        if (xfer) begin
          skid_to_main = 1'b1;
          state_nxt    = ST_ONE;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != ST_TWO);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_dest  <= '0;
      skid_data <= '0;
      skid_dest <= '0;
    end else begin
      if (load_main) begin
        out_data <= result;
        out_dest <= in_dest;
      end else if (skid_to_main) begin
        out_data <= skid_data;
        out_dest <= skid_dest;
      end
      if (load_skid) begin
        skid_data <= result;
        skid_dest <= in_dest;
      end
    end
  end

`ifdef ULA_EXEC_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    op_count <= '0;
    else if (accept) op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ula_exec_stage.sv
// Self-checking bench: directed vector table, skid/reset corner cases, random traffic vs queue model.
module tb_ula_exec_stage;

  logic        clock, reset_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_sel;
  logic [31:0] in_data1, in_data2;
  logic [4:0]  in_dest;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_dest;
`ifdef ULA_EXEC_CNT_EN
  logic [15:0] op_count;
`endif

  ula_exec_stage #(.DATA_W(32), .DEST_W(5)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_dest   (in_dest),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_dest  (out_dest)
`ifdef ULA_EXEC_CNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int n_out = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference ALU from the arithmetic rules, using wide integers
  function automatic logic [31:0] ref_alu(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    longint unsigned x, y, m;
    x = a; y = b; m = 64'h1_0000_0000;
    case (s)
      3'd0:    return 32'((x + y) % m);
      3'd1:    return 32'((x + m - y) % m);
      3'd2:    return (x > y) ? 32'd1 : 32'd0;
      3'd3:    return (x < y) ? 32'd1 : 32'd0;
      3'd4:    return (x == y) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] d;
    logic [4:0]  t;
  } exp_t;

  exp_t        q[$];
  logic        hold_v;
  logic [31:0] hold_d;
  logic [4:0]  hold_t;
  logic [15:0] acc_cnt;

  // Monitor: inputs change at posedge+1, so the negedge view is what the next edge will use
  always @(negedge clock) begin
    if (!reset_n) begin
      q.delete();
      hold_v  = 1'b0;
      acc_cnt = '0;
    end else begin
      exp_t e;
      check("mon_out_valid", 64'(out_valid), 64'(q.size() != 0));
      check("mon_in_ready", 64'(in_ready), 64'(q.size() < 2));
`ifdef ULA_EXEC_CNT_EN
      check("mon_op_count", 64'(op_count), 64'(acc_cnt));
`endif
      if (hold_v) begin
        check("hold_data", 64'(out_data), 64'(hold_d));
        check("hold_dest", 64'(out_dest), 64'(hold_t));
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_t = out_dest;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output: got data %0h with empty model queue", out_data);
        end else begin
          e = q.pop_front();
          check("order_data", 64'(out_data), 64'(e.d));
          check("order_dest", 64'(out_dest), 64'(e.t));
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        e.d = ref_alu(in_sel, in_data1, in_data2);
        e.t = in_dest;
        q.push_back(e);
        acc_cnt = acc_cnt + 16'd1;
      end
    end
  end

  // Present one op and hold it until accepted (bounded wait)
  task automatic send(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    in_valid = 1'b1; in_sel = s; in_data1 = a; in_data2 = b; in_dest = t;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock); #1;
        in_valid = 1'b0;
        return;
      end
    end
    tests++; fails++;
    $display("FAIL send_timeout: got no accept in 50 cycles, required accept");
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] a, b;
    logic [4:0]  dest;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[12];

  initial begin
    int n0, c0;
    vt[0]  = '{3'b000, 32'd5,          32'd7, 5'd3,  32'd12};
    vt[1]  = '{3'b001, 32'd0,          32'd1, 5'd4,  32'hFFFF_FFFF};
    vt[2]  = '{3'b010, 32'd9,          32'd4, 5'd5,  32'd1};
    vt[3]  = '{3'b100, 32'd6,          32'd7, 5'd6,  32'd0};
    vt[4]  = '{3'b111, 32'd123,        32'd9, 5'd7,  32'd0};
    vt[5]  = '{3'b011, 32'd3,          32'd8, 5'd8,  32'd1};
    vt[6]  = '{3'b100, 32'd5,          32'd5, 5'd9,  32'd1};
    vt[7]  = '{3'b000, 32'hFFFF_FFFF,  32'd2, 5'd10, 32'd1};
    vt[8]  = '{3'b010, 32'd4,          32'd9, 5'd11, 32'd0};
    vt[9]  = '{3'b011, 32'd8,          32'd3, 5'd12, 32'd0};
    vt[10] = '{3'b101, 32'd1,          32'd1, 5'd13, 32'd0};
    vt[11] = '{3'b001, 32'd3,          32'd5, 5'd31, 32'hFFFF_FFFE};

    clock = 0; reset_n = 0; in_valid = 0; in_sel = 0;
    in_data1 = 0; in_data2 = 0; in_dest = 0; out_ready = 0;

    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_dest", 64'(out_dest), 64'd0);
`ifdef ULA_EXEC_CNT_EN
    check("rst_op_count", 64'(op_count), 64'd0);
`endif

    // First accept on the very first edge after release
    @(posedge clock); #1;
    reset_n = 1; out_ready = 1;
    in_valid = 1; in_sel = 3'b000; in_data1 = 5; in_data2 = 7; in_dest = 3;
    @(posedge clock); #1;
    in_valid = 0;
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_data", 64'(out_data), 64'd12);
    check("first_dest", 64'(out_dest), 64'd3);

    // Vector table, one op per cycle with out_ready high
    for (int i = 0; i < 12; i++) begin
      in_valid = 1; in_sel = vt[i].sel; in_data1 = vt[i].a; in_data2 = vt[i].b; in_dest = vt[i].dest;
      @(posedge clock); #1;
      in_valid = 0;
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_data", i), 64'(out_data), 64'(vt[i].exp));
      check($sformatf("vec%0d_dest", i), 64'(out_dest), 64'(vt[i].dest));
    end
    @(posedge clock); #1;

    // Backpressure: A,B fill the buffer, C stalls until drain
    out_ready = 0;
    n0 = n_out;
    send(3'b000, 32'd100, 32'd1, 5'd1);
    send(3'b000, 32'd200, 32'd2, 5'd2);
    check("bp_in_ready_two", 64'(in_ready), 64'd0);
    in_valid = 1; in_sel = 3'b000; in_data1 = 300; in_data2 = 3; in_dest = 5'd3;
    repeat (3) @(posedge clock);
    #1;
    check("bp_still_stalled", 64'(in_ready), 64'd0);
    check("bp_hold_a", 64'(out_data), 64'd101);
    out_ready = 1;
    send(3'b000, 32'd300, 32'd3, 5'd3);
    repeat (4) @(posedge clock);
    #1;
    check("bp_delivered", 64'(n_out - n0), 64'd3);

    // Reset while two results are buffered
    out_ready = 0;
    send(3'b001, 32'd50, 32'd8, 5'd20);
    send(3'b001, 32'd60, 32'd8, 5'd21);
    #2 reset_n = 0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_data", 64'(out_data), 64'd0);
    check("midrst_out_dest", 64'(out_dest), 64'd0);
    @(posedge clock); #1;
    reset_n = 1; out_ready = 1;
    repeat (4) @(posedge clock);
    #1;
    check("midrst_no_stale", 64'(out_valid), 64'd0);

    // Full-rate stream of 100 ops
    do_reset();
    out_ready = 1;
    n0 = n_out; c0 = cyc;
    for (int i = 0; i < 100; i++)
      send(3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 15), 5'($urandom));
    check("stream_cycles", 64'(cyc - c0), 64'd100);
    repeat (3) @(posedge clock);
    #1;
    check("stream_count", 64'(n_out - n0), 64'd100);
`ifdef ULA_EXEC_CNT_EN
    check("stream_op_count", 64'(op_count), 64'd100);
`endif

    // Random traffic with random backpressure
    for (int i = 0; i < 800; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 9));
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_sel    = 3'($urandom_range(0, 7));
      in_data1  = a;
      in_data2  = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 9)));
      in_dest   = 5'($urandom);
      @(posedge clock); #1;
    end
    in_valid = 0; out_ready = 1;
    repeat (4) @(posedge clock);
    #1;
    check("random_drained", 64'(out_valid), 64'd0);

`ifdef ULA_EXEC_CNT_EN
    do_reset();
    out_ready = 1; in_valid = 1; in_sel = 3'b000; in_data1 = 1; in_data2 = 1; in_dest = 0;
    repeat (65537) @(posedge clock);
    #1;
    in_valid = 0;
    check("wrap_op_count", 64'(op_count), 64'd1);
`endif

    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
